// File: rtl/seg_scan_decoder.sv
// Scanned 7-segment display decoder: recovers 8 BCD digits from an/seg.
// Optional error counter port and logic: define SEG_SCAN_ERR_CNT_EN.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic        frame_valid,
  output logic        digit_err,
  output logic        an_err
`ifdef SEG_SCAN_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [7:0]  an_q1, an_q2;
  logic [6:0]  seg_q1, seg_q2;
  logic [7:0]  cnt;
  logic [7:0]  seen;
  logic [31:0] partial;

  logic       stable;
  logic       capture;
  logic [7:0] an_low;
  logic       an_hot;
  logic       an_idle;
  logic       dig_wr;
  logic       an_bad;
  logic       seg_bad;
  logic       err_hit;
  logic [3:0] digit_val;
  logic [7:0] wr_mask;
  logic [7:0] seen_base;
  logic       frame_done;

  // Two-flop synchronizers; idle values match a blank, deselected display
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q1  <= 8'hFF;
      an_q2  <= 8'hFF;
      seg_q1 <= 7'h7F;
      seg_q2 <= 7'h7F;
    end else begin
      an_q1  <= an;
      an_q2  <= an_q1;
      seg_q1 <= seg;
      seg_q2 <= seg_q1;
    end
  end

  // The value loaded into the second stage is the new synchronized value,
  // so comparing the stages detects a change one edge before it lands.
  always_comb begin
    stable     = ({an_q1, seg_q1} == {an_q2, seg_q2});
    capture    = stable && (cnt == CNT_LAST);
    an_low     = ~an_q2;
    an_hot     = (an_low != 8'h00) &&
                 ((an_low & (an_low - 8'd1)) == 8'h00);
    an_idle    = (an_q2 == 8'hFF);
    frame_done = (seen == 8'hFF);
  end

  // Active-low segment pattern to digit value
  always_comb begin
    digit_val = 4'hF;
    case (seg_q2)
      7'h40:   digit_val = 4'h0;
      7'h79:   digit_val = 4'h1;
      7'h24:   digit_val = 4'h2;
      7'h30:   digit_val = 4'h3;
      7'h19:   digit_val = 4'h4;
      7'h12:   digit_val = 4'h5;
      7'h02:   digit_val = 4'h6;
      7'h78:   digit_val = 4'h7;
      7'h00:   digit_val = 4'h8;
      7'h10:   digit_val = 4'h9;
      7'h7F:   digit_val = 4'hE;
      default: digit_val = 4'hF;
    endcase
  end

  // Capture qualification and next seen mask
  always_comb begin
    seg_bad   = (digit_val == 4'hF);
    dig_wr    = capture && an_hot;
    an_bad    = capture && !an_hot && !an_idle;
    err_hit   = an_bad || (dig_wr && seg_bad);
    wr_mask   = dig_wr ? an_low : 8'h00;
    seen_base = (frame_done || err_clr) ? 8'h00 : seen;
  end

  // Stability counter saturating at STABLE_CYCLES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 8'd0;
    end else if (!stable) begin
      cnt <= 8'd0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Partial frame assembly, frame publish and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen        <= 8'h00;
      partial     <= 32'h0;
      digits      <= 32'h0;
      frame_valid <= 1'b0;
      digit_err   <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      seen        <= seen_base | wr_mask;
      frame_valid <= frame_done;
      if (frame_done) begin
        digits <= partial;
      end
      for (int i = 0; i < 8; i++) begin
        if (wr_mask[i]) begin
          partial[4*i +: 4] <= digit_val;
        end
      end
      digit_err <= (digit_err && !err_clr) || (dig_wr && seg_bad);
      an_err    <= (an_err && !err_clr) || an_bad;
    end
  end

`ifdef SEG_SCAN_ERR_CNT_EN
  // Saturating count of error-raising captures
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= {7'd0, err_hit};
    end else if (err_hit && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random hold sequences
// checked against a hold-level reference model.
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        err_clr;
  logic [31:0] digits;
  logic        frame_valid;
  logic        digit_err;
  logic        an_err;
`ifdef SEG_SCAN_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Lit-segment masks (bit0=a .. bit6=g) for values 0..9
  logic [6:0] on_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [3:0]  m_part [8];
  logic [7:0]  m_seen;
  logic [31:0] m_digits;
  logic        m_derr;
  logic        m_aerr;
  int          m_ecnt;
  int          fv_exp;
  int          fv_seen;
  logic        fv_prev;
  logic [14:0] prev_in;
  int          fv_at;
  int          sweep;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk),
    .reset(reset),
    .an(an),
    .seg(seg),
    .err_clr(err_clr),
    .digits(digits),
    .frame_valid(frame_valid),
    .digit_err(digit_err),
    .an_err(an_err)
`ifdef SEG_SCAN_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int v);
    return ~on_pat[v];
  endfunction

  function automatic logic [7:0] sel(input int d);
    logic [7:0] one;
    one = 8'd1 << d;
    return ~one;
  endfunction

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    logic [6:0] lit;
    lit = ~s;
    if (lit == 7'h00) return 4'hE;
    for (int v = 0; v < 10; v++)
      if (on_pat[v] == lit) return 4'(v);
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_part[i] = 4'h0;
    m_seen   = 8'h00;
    m_digits = 32'h0;
    m_derr   = 1'b0;
    m_aerr   = 1'b0;
    m_ecnt   = 0;
    fv_prev  = 1'b0;
    prev_in  = {8'hFF, 7'h7F};
  endtask

  task automatic model_capture(input logic [7:0] a,
                               input logic [6:0] s);
    int nsel;
    int d;
    nsel = 0;
    d = 0;
    for (int i = 0; i < 8; i++)
      if (!a[i]) begin
        nsel++;
        d = i;
      end
    if (nsel == 1) begin
      m_part[d] = ref_decode(s);
      m_seen[d] = 1'b1;
      if (m_part[d] == 4'hF) begin
        m_derr = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
      end
    end else if (nsel > 1) begin
      m_aerr = 1'b1;
      if (m_ecnt < 255) m_ecnt++;
    end
    if (m_seen == 8'hFF) begin
      for (int i = 0; i < 8; i++) m_digits[4*i +: 4] = m_part[i];
      m_seen = 8'h00;
      fv_exp++;
    end
  endtask

  task automatic tick(output logic fv);
    @(negedge clk);
    fv = frame_valid;
    if (fv) begin
      fv_seen++;
      chk("fv_pulse_width", 32'(fv_prev), 32'd0);
    end
    fv_prev = fv;
  endtask

  // Hold one input value for len cycles; a captured hold needs S+1 edges
  task automatic hold(input logic [7:0] a, input logic [6:0] s,
                      input int len, output int first_fv);
    logic fv;
    an = a;
    seg = s;
    first_fv = -1;
    for (int c = 1; c <= len; c++) begin
      tick(fv);
      if (fv && first_fv < 0) first_fv = c;
    end
    if (len >= S + 1) model_capture(a, s);
    prev_in = {a, s};
  endtask

  task automatic clear_errs();
    logic fv;
    err_clr = 1'b1;
    tick(fv);
    err_clr = 1'b0;
    m_derr = 1'b0;
    m_aerr = 1'b0;
    m_seen = 8'h00;
    m_ecnt = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_digits"}, digits, m_digits);
    chk({tag, "_digit_err"}, 32'(digit_err), 32'(m_derr));
    chk({tag, "_an_err"}, 32'(an_err), 32'(m_aerr));
    chk({tag, "_frames"}, 32'(fv_seen), 32'(fv_exp));
`ifdef SEG_SCAN_ERR_CNT_EN
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_ecnt));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    an = 8'hFF;
    seg = 7'h7F;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digits", digits, 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_digit_err", 32'(digit_err), 32'd0);
    chk("rst_an_err", 32'(an_err), 32'd0);
`ifdef SEG_SCAN_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    reset = 1'b1;
    model_reset();
  endtask

  task automatic pick(output logic [7:0] a, output logic [6:0] s);
    int r;
    do begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        a = sel(sweep % 8);
        sweep++;
      end else if (r == 7) a = 8'hFF;
      else a = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) s = pat($urandom_range(0, 9));
      else if (r == 7) s = 7'h7F;
      else s = 7'($urandom);
    end while ({a, s} == prev_in);
  endtask

  initial begin
    logic [7:0] ra;
    logic [6:0] rs;
    int len;
    fv_exp = 0;
    fv_seen = 0;
    sweep = 0;
    do_reset();

    // Full in-order scan, frame one cycle after the last capture
    for (int d = 0; d < 7; d++) hold(sel(d), pat(d + 1), 10, fv_at);
    hold(sel(7), pat(8), 10, fv_at);
    chk("scan_frame_latency", 32'(fv_at), 32'(S + 3));
    chk("scan_digits", digits, 32'h87654321);
    check_state("scan");

    // A 3-cycle hold is too short to capture
    hold(sel(0), pat(5), 3, fv_at);
    for (int d = 1; d < 8; d++) hold(sel(d), pat(d), 10, fv_at);
    check_state("short_hold");
    hold(sel(0), pat(9), 10, fv_at);
    chk("short_frame_latency", 32'(fv_at), 32'(S + 3));
    chk("short_digit0", 32'(digits[3:0]), 32'h9);
    check_state("short_done");

    // Re-captured digit 3: newest value wins
    for (int d = 0; d < 3; d++) hold(sel(d), pat(d), 10, fv_at);
    hold(sel(3), 7'h00, 10, fv_at);
    hold(sel(4), pat(4), 10, fv_at);
    hold(sel(5), pat(5), 10, fv_at);
    hold(sel(3), pat(2), 10, fv_at);
    hold(sel(6), pat(6), 10, fv_at);
    hold(sel(7), pat(7), 10, fv_at);
    chk("overwrite_digit3", 32'(digits[15:12]), 32'h2);
    check_state("overwrite");

    // Illegal anode pattern, then clear
    do_reset();
    hold(8'hFC, pat(1), 10, fv_at);
    chk("an_err_set", 32'(an_err), 32'd1);
    check_state("an_bad");
    clear_errs();
    chk("an_err_clr", 32'(an_err), 32'd0);
    check_state("an_clr");

    // Undecodable segments, then reset discards a partial frame
    do_reset();
    hold(sel(0), 7'h55, 10, fv_at);
    for (int d = 1; d < 8; d++) hold(sel(d), pat(d), 10, fv_at);
    chk("bad_seg_digit0", 32'(digits[3:0]), 32'hF);
    chk("bad_seg_flag", 32'(digit_err), 32'd1);
    check_state("bad_seg");
    for (int d = 0; d < 5; d++) hold(sel(d), pat(d), 10, fv_at);
    do_reset();
    hold(8'hFF, pat(3), S + 6, fv_at);
    chk("rst_mid_no_frame", 32'(fv_at), 32'hFFFFFFFF);
    check_state("rst_mid");

    // Random hold sequences
    for (int n = 0; n < 200; n++) begin
      pick(ra, rs);
      if ($urandom_range(0, 9) < 3) len = $urandom_range(1, S);
      else len = $urandom_range(S + 3, S + 6);
      hold(ra, rs, len, fv_at);
      check_state("rand");
      if (len > S && $urandom_range(0, 9) == 0) begin
        clear_errs();
        check_state("rand_clr");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical synchronized samples required before a digit is captured.
REQ-002 clk  input  1  single clock; all state is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 an  input  8  scanned anode enables, active-low; an[i]=0 selects digit i.
REQ-005 seg  input  7  scanned segments, active-low; seg[0]=a, seg[1]=b, ..., seg[6]=g.
REQ-006 err_clr  input  1  synchronous clear of sticky error flags and the partial-frame mask.
REQ-007 digits  output  32  last complete frame; digit i at bits [4i+3:4i].
REQ-008 frame_valid  output  1  one-cycle pulse when digits is updated.
REQ-009 digit_err  output  1  sticky flag: an undecodable segment pattern was captured.
REQ-010 an_err  output  1  sticky flag: a stable an value was neither one-hot-low nor all ones.

Function
REQ-011 an and seg SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Stability counter: reset to 0 whenever synchronized {an,seg} differs from its previous-cycle value; otherwise increment, saturating at STABLE_CYCLES.
REQ-013 Capture SHALL occur exactly once per stable period, on the edge where the counter reaches STABLE_CYCLES; no further capture until {an,seg} changes.
REQ-014 Capture, an one-hot-low at index i: decode seg into partial[i], set seen[i].
REQ-015 Capture, an = 8'hFF: no write, no error (inter-digit blanking).
REQ-016 Capture, any other an: set an_err; no write, seen unchanged.
REQ-017 Decode: the 10 standard 7-segment patterns map to 0..9 (6 includes a, 9 includes d); all segments off maps to 4'hE without error; any other pattern maps to 4'hF and sets digit_err.
REQ-018 A digit captured again before frame completion SHALL be overwritten; the newest value wins; capture order is irrelevant.
REQ-019 On the edge after seen becomes 8'hFF: digits <= partial (all 8 atomically), frame_valid = 1 for that cycle, seen <= 0.
REQ-020 Latency: an input change stable from edge N is captured at edge N+1+STABLE_CYCLES (2 sync stages included); frame output follows the final capture by 1 cycle.
REQ-021 err_clr SHALL clear digit_err, an_err and seen; it SHALL NOT alter digits or partial; a capture in the same cycle SHALL take effect after the clear (the captured bit/flag is set).
REQ-022 digits SHALL hold its value between frames; frame_valid SHALL never be high two consecutive cycles.

Reset
REQ-023 While reset=0: synchronizers = 8'hFF/7'h7F, counter = 0, seen = 0, partial = 0, digits = 32'h0, frame_valid = 0, digit_err = 0, an_err = 0 (and err_cnt = 0 when compiled in).
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid SHALL be emitted for it after release.
REQ-025 The first capture after reset release SHALL require a full STABLE_CYCLES stable period.

Configuration
REQ-026 With macro SEG_SCAN_ERR_CNT_EN defined, output err_cnt (8 bits) SHALL count every capture setting digit_err or an_err, saturating at 255, cleared by reset and err_clr.
REQ-027 Without SEG_SCAN_ERR_CNT_EN, port err_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Scan digits 0..7 with values 1..8 in order, each held 10 cycles, STABLE_CYCLES=4 -> one frame_valid, digits=32'h87654321, no errors.
REQ-029 Hold an=8'hFE 3 cycles then change (STABLE_CYCLES=4) -> no capture, seen unchanged.
REQ-030 Scan frame with digit 3 seg=7'h00 (all on, =8) twice, second time seg pattern for 2 -> digits[15:12]=4'h2 in the frame.
REQ-031 Stable an=8'hFC -> an_err=1, no write; err_clr pulse -> an_err=0; with SEG_SCAN_ERR_CNT_EN, err_cnt=1 before clear, 0 after.
REQ-032 Invalid seg=7'h55 on digit 0 -> digit_err=1, frame digit 0 = 4'hF; reset asserted after 5 digits -> no frame_valid, digits=0.
